int_div: RTL and testbench

//  Iterative radix-2 restoring integer divider; the sequential counterpart of the stage3 integer

---
 rtl/riscv_fu_pkg.sv | 26 ++
 rtl/div_step.sv | 24 ++
 rtl/int_div.sv | 134 +++++++++++++
 tb/tb_int_div.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fu_pkg.sv
// Shared types for the stage3 functional units: divider op encoding and divider FSM states.
package riscv_fu_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_e;

    function automatic logic div_op_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic div_op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// Purpose: one radix-2 restoring division iteration (shift in next dividend bit, conditional subtract).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   rem_nxt,
    output logic [N-1:0] q_nxt
);
    localparam int W = N + 1;

    logic [N:0] shifted;
    logic       fits;

    // The partial remainder is always below d, so its top bit is zero and the shift drops nothing.
    assign shifted = W'({rem, q[N-1]});
    assign fits    = shifted >= {1'b0, d};
    assign rem_nxt = fits ? (shifted - {1'b0, d}) : shifted;
    assign q_nxt   = {q[N-2:0], fits};

endmodule

// File: rtl/int_div.sv
// Purpose: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; INT_DIV_EARLY_OUT_EN enables early out.
// Latency: N+2 cycles accept-to-out_valid; 2 cycles for div-by-zero, signed overflow, |a|<|b| with early out.
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready; flush wins.
module int_div
    import riscv_fu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  div_op_e      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);
    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    div_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N:0]    rem, rem_step, rem_init;
    logic [N-1:0]  quo, quo_step, quo_init, dvs;
    logic          is_rem, q_neg, r_neg, div_zero;

    logic          accept, signed_op, b_zero, early;
    logic [N-1:0]  a_mag, b_mag, r_mag, q_fix, r_fix;

    assign signed_op = div_op_signed(op);
    assign a_mag     = (signed_op && a[N-1]) ? -a : a;
    assign b_mag     = (signed_op && b[N-1]) ? -b : b;
    assign b_zero    = (b == '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

`ifdef INT_DIV_EARLY_OUT_EN
    logic ovf, small;

    assign ovf   = signed_op && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
    assign small = a_mag < b_mag;
    assign early = b_zero || ovf || small;

    // Trivial cases preload exactly what N iterations would have left in rem/quo.
    always_comb begin
        rem_init = '0;
        quo_init = a_mag;
        if (b_zero) begin
            rem_init = {1'b0, a_mag};
            quo_init = '1;
        end else if (ovf) begin
            rem_init = '0;
            quo_init = {1'b1, {(N-1){1'b0}}};
        end else if (small) begin
            rem_init = {1'b0, a_mag};
            quo_init = '0;
        end
    end
`else
    assign early    = 1'b0;
    assign rem_init = '0;
    assign quo_init = a_mag;
`endif

    div_step #(.N(N)) u_step (
        .rem     (rem),
        .q       (quo),
        .d       (dvs),
        .rem_nxt (rem_step),
        .q_nxt   (quo_step)
    );

    // Divide by zero must give all ones even when the quotient sign says negate.
    assign r_mag = N'(rem);
    assign q_fix = div_zero ? '1 : (q_neg ? -quo : quo);
    assign r_fix = r_neg ? -r_mag : r_mag;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = early ? FIXUP : CALC;
            CALC:    if (cnt == '0) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            is_rem   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else begin
            if (accept) begin
                cnt      <= CNT_LAST;
                rem      <= rem_init;
                quo      <= quo_init;
                dvs      <= b_mag;
                is_rem   <= div_op_is_rem(op);
                q_neg    <= signed_op && (a[N-1] ^ b[N-1]);
                r_neg    <= signed_op && a[N-1];
                div_zero <= b_zero;
            end else if (state == CALC) begin
                rem <= rem_step;
                quo <= quo_step;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (state == FIXUP) begin
                result <= is_rem ? r_fix : q_fix;
            end
        end
    end

endmodule

// File: tb/tb_int_div.sv
// Directed and random checks of int_div (N=32) against spec constants and a reference model.
module tb_int_div;
    import riscv_fu_pkg::*;

    localparam int N        = 32;
    localparam int FULL_LAT = N + 2;
`ifdef INT_DIV_EARLY_OUT_EN
    localparam int FAST_LAT = 2;
`else
    localparam int FAST_LAT = N + 2;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         flush     = 1'b0;
    logic         out_ready = 1'b1;
    div_op_e      op        = DIVU;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] result;

    int           tests = 0;
    int           fails = 0;
    logic [N-1:0] sb[$];

    always #5 clk = ~clk;

    int_div #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_model(input div_op_e o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic sgn;
        logic rm;
        sgn = (o == DIV) || (o == REM);
        rm  = (o == REM) || (o == REMU);
        if (y == '0) return rm ? x : '1;
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return rm ? 32'd0 : x;
        if (sgn) return rm ? ($signed(x) % $signed(y)) : ($signed(x) / $signed(y));
        return rm ? (x % y) : (x / y);
    endfunction

    function automatic int exp_lat(input div_op_e o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic         sgn;
        logic         quick;
        logic [N-1:0] ma;
        logic [N-1:0] mb;
        sgn   = (o == DIV) || (o == REM);
        ma    = (sgn && x[N-1]) ? -x : x;
        mb    = (sgn && y[N-1]) ? -y : y;
        quick = (y == '0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) || (ma < mb);
        return quick ? FAST_LAT : FULL_LAT;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'($urandom_range(1, 16));
            2:       return 32'h8000_0000;
            3:       return '1;
            default: return $urandom();
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
    task automatic run_op(input div_op_e o, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] expv, input int stall, input string tag);
        int           lat;
        logic [N-1:0] exp_r;
        sb.push_back(expv);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        exp_r = sb.pop_front();
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, x, y)));
        chk({tag, "_res"}, 64'(result), 64'(exp_r));
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk({tag, "_hold_res"}, 64'(result), 64'(exp_r));
                chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, "_post_vld"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(DIVU, 32'd100, 32'd7, 32'd14, 0, "divu_100_7");
        run_op(REMU, 32'd100, 32'd7, 32'd2, 0, "remu_100_7");
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_m7_2");
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_m7_2");
        run_op(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, "rem_7_m2");
        run_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_by0");
        run_op(REM, 32'd5, 32'd0, 32'd5, 0, "rem_by0");
        run_op(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, "div_neg_by0");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_ovf");
        run_op(DIVU, 32'd3, 32'd10, 32'd0, 0, "divu_small");
        run_op(REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 0, "rem_small_neg");
        run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, "divu_max");

        run_op(DIVU, 32'd1000, 32'd10, 32'd100, 10, "stall");

        // Flush during the fifth CALC iteration.
        in_valid = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // Flush and a request in the same cycle: the request is dropped.
        in_valid = 1'b1; flush = 1'b1; op = DIVU; a = 32'd50; b = 32'd5;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_wins_rdy", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("flush_wins_no_result", 64'(seen), 64'd0);
        run_op(DIVU, 32'd9, 32'd3, 32'd3, 0, "after_flush");

        // Asynchronous reset in the middle of CALC.
        in_valid = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(REMU, 32'd100, 32'd7, 32'd2, 0, "after_arst");

        for (int i = 0; i < 1500; i++) begin
            div_op_e      o;
            logic [N-1:0] x;
            logic [N-1:0] y;
            o = div_op_e'($urandom_range(0, 3));
            x = pick();
            y = pick();
            run_op(o, x, y, ref_model(o, x, y), int'($urandom_range(0, 2)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
